bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the iterative shift-and-add-3 method (double dabble).
- Sits directly upstream of the per-digit 7-segment decoders.
- Each 4-bit BCD digit of bcd_out drives one decoder instance, so a binary count or sensor value can be shown in decimal on the HEX displays.
- Conversion is started by a pulse. The result is held stable until the next conversion completes.

---
 rtl/bin_to_bcd_seq_pkg.sv | 32 +++
 rtl/bin_to_bcd_seq_add3.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 175 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_pkg
// Description : Shared definitions for the sequential binary-to-BCD converter.
//               Provides the BCD nibble width, the converter state encoding
//               and a pow10() helper that is evaluated at elaboration to build
//               the overflow threshold 10^DIGITS.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

  localparam int BCD_NIBBLE_W = 4;

  // Wide enough to hold 10^6 (needs 20 bits) with margin.
  localparam int POW10_W = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [POW10_W-1:0] pow10(input int n);
    logic [POW10_W-1:0] r;
    r = POW10_W'(1);
    for (int i = 0; i < n; i++) begin
      r = r * POW10_W'(10);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational double-dabble correction cell: a BCD nibble that
//               is 5 or more gets 3 added so that the following left shift
//               carries correctly into the next decimal digit.
// Ports       : din  - BCD nibble before correction
//               dout - corrected nibble
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] din,
  output logic [BCD_NIBBLE_W-1:0] dout
);

  always_comb begin
    if (din >= BCD_NIBBLE_W'(5)) begin
      dout = din + BCD_NIBBLE_W'(3);
    end else begin
      dout = din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3). A start
//               pulse in IDLE captures bin_in; WIDTH shift steps later the
//               BCD result is registered on bcd_out with a one-cycle done
//               pulse. Values >= 10^DIGITS saturate to all nines and raise
//               overflow.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               start    - conversion request, honoured only in IDLE
//               bin_in   - unsigned binary value, sampled on accept edge
//               busy     - conversion in progress
//               done     - one-cycle pulse when bcd_out is updated
//               bcd_out  - registered BCD result, digit 0 = units
//               overflow - last converted value was >= 10^DIGITS
//               blank_n  - (BIN_TO_BCD_BLANK_EN only) per-digit leading-zero
//                          suppression, 0 = blank this digit
// Options     : define BIN_TO_BCD_BLANK_EN to add the blank_n output.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [WIDTH-1:0]                 bin_in,
  output logic                             busy,
  output logic                             done,
  output logic [BCD_NIBBLE_W*DIGITS-1:0]   bcd_out,
  output logic                             overflow
`ifdef BIN_TO_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]                blank_n
`endif
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [POW10_W-1:0] OVF_LIMIT = pow10(DIGITS);
  localparam logic [BCD_W-1:0]   ALL_NINES = {DIGITS{4'h9}};

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_new;
  logic               in_ovf;

  // Correct every BCD nibble in parallel, then shift once per step.
  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (sr_q  [WIDTH + BCD_NIBBLE_W*k +: BCD_NIBBLE_W]),
        .dout (sr_adj[WIDTH + BCD_NIBBLE_W*k +: BCD_NIBBLE_W])
      );
    end
  endgenerate

  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  assign bcd_new  = ovf_pend_q ? ALL_NINES : sr_shift[SR_W-1:WIDTH];
  assign in_ovf   = (POW10_W'(bin_in) >= OVF_LIMIT);

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_n_q, blank_n_d;
  logic [DIGITS-1:0] blank_new;

  // Scan from the most significant digit down; a digit is shown once any
  // digit at or above it is non-zero. The units digit is always shown.
  always_comb begin : p_blank
    logic any_nz;
    any_nz    = 1'b0;
    blank_new = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz       = any_nz | (|bcd_new[BCD_NIBBLE_W*k +: BCD_NIBBLE_W]);
      blank_new[k] = any_nz | (k == 0);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
    blank_n_d  = blank_n_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = {{BCD_W{1'b0}}, bin_in};
          cnt_d      = CNT_W'(WIDTH);
          ovf_pend_d = in_ovf;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d     = bcd_new;
          ovf_d     = ovf_pend_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
`ifdef BIN_TO_BCD_BLANK_EN
          blank_n_d = blank_new;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_n_q  <= DIGITS'(1);
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_n_q  <= blank_n_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
  assign blank_n  = blank_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. A default instance
//               (WIDTH=10, DIGITS=4) and a wide instance (WIDTH=14) are
//               exercised; expected results are queued when a conversion is
//               started and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [9:0]  bin_in = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;

  logic        start_w = 1'b0;
  logic [13:0] bin_w = '0;
  logic        busy_w, done_w, overflow_w;
  logic [15:0] bcd_out_w;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [3:0]  blank_n, blank_n_w;
`endif

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    .blank_n  (blank_n)
`endif
  );

  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_w),
    .bin_in   (bin_w),
    .busy     (busy_w),
    .done     (done_w),
    .bcd_out  (bcd_out_w),
    .overflow (overflow_w)
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    .blank_n  (blank_n_w)
`endif
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } exp_t;

  typedef struct {
    int   bin;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  exp_t sb_w[$];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_cnt_w = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic prev_done_w = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent decimal model: arithmetic digit extraction.
  function automatic exp_t model(input int v);
    exp_t e;
    int   t;
    logic any_nz;
    if (v >= 10000) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      t = v;
      for (int k = 0; k < 4; k++) begin
        e.bcd[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    any_nz = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      any_nz     = any_nz | (e.bcd[4*k +: 4] != 4'd0);
      e.blank[k] = any_nz | (k == 0);
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: default instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        exp_t e;
        done_cnt++;
        check("done_single", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got bcd 0x%0h, expected no done", bcd_out);
        end else begin
          e = sb.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e.bcd));
          check("overflow", 32'(overflow), 32'(e.ovf));
`ifdef BIN_TO_BCD_BLANK_EN
          check("blank_n", 32'(blank_n), 32'(e.blank));
`endif
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Scoreboard: wide instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_w) begin
        exp_t e;
        done_cnt_w++;
        check("w_done_single", 32'(prev_done_w), 32'd0);
        if (sb_w.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL w_unexpected_done: got bcd 0x%0h, expected no done", bcd_out_w);
        end else begin
          e = sb_w.pop_front();
          check("w_bcd_out", 32'(bcd_out_w), 32'(e.bcd));
          check("w_overflow", 32'(overflow_w), 32'(e.ovf));
`ifdef BIN_TO_BCD_BLANK_EN
          check("w_blank_n", 32'(blank_n_w), 32'(e.blank));
`endif
        end
      end
      prev_done_w = done_w;
    end else begin
      prev_done_w = 1'b0;
    end
  end

  // Wait (bounded) for done on the default instance; returns cycle stamp.
  task automatic wait_done(input string tag, output int c);
    bit seen;
    seen = 1'b0;
    c = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        c = cyc;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", tag);
    end
  endtask

  // One conversion with latency, busy and hold checks.
  task automatic run(input bit w, input int v, input exp_t e, input string tag);
    int  n;
    bit  seen;
    if (w) begin
      sb_w.push_back(e);
      bin_w   = 14'(v);
      start_w = 1'b1;
    end else begin
      sb.push_back(e);
      bin_in = 10'(v);
      start  = 1'b1;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_w = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) check({tag, "_busy"}, 32'(w ? busy_w : busy), 32'd1);
      if (w ? done_w : done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", tag);
    end else begin
      check({tag, "_latency"}, 32'(n), w ? 32'd14 : 32'd10);
      check({tag, "_busy_at_done"}, 32'(w ? busy_w : busy), 32'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, 32'(w ? bcd_out_w : bcd_out), 32'(e.bcd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   c0, c1, c2, d0;
    int   v;

    tbl[0].bin = 987;  tbl[0].e = '{16'h0987, 1'b0, 4'b0111};
    tbl[1].bin = 0;    tbl[1].e = '{16'h0000, 1'b0, 4'b0001};
    tbl[2].bin = 9;    tbl[2].e = '{16'h0009, 1'b0, 4'b0001};
    tbl[3].bin = 10;   tbl[3].e = '{16'h0010, 1'b0, 4'b0011};
    tbl[4].bin = 999;  tbl[4].e = '{16'h0999, 1'b0, 4'b0111};
    tbl[5].bin = 42;   tbl[5].e = '{16'h0042, 1'b0, 4'b0011};
    tbl[6].bin = 1000; tbl[6].e = '{16'h1000, 1'b0, 4'b1111};
    tbl[7].bin = 1023; tbl[7].e = '{16'h1023, 1'b0, 4'b1111};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_w_bcd", 32'(bcd_out_w), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    check("rst_blank", 32'(blank_n), 32'b0001);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Table-driven conversions
    for (int i = 0; i < 8; i++) begin
      run(1'b0, tbl[i].bin, tbl[i].e, $sformatf("tbl%0d", i));
    end

    // Reset mid-conversion aborts with no done pulse
    d0 = done_cnt;
    bin_in = 10'd999;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    check("abort_blank", 32'(blank_n), 32'b0001);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_busy_after", 32'(busy), 32'd0);

    // start held high: back-to-back every WIDTH+1 cycles; bin_in changes
    // while busy must not affect the conversion in flight
    sb.push_back(model(111));
    bin_in = 10'd111;
    start  = 1'b1;
    @(posedge clk);
    #1 bin_in = 10'd222;
    sb.push_back(model(222));
    wait_done("cont0", c0);
    @(posedge clk);
    #1 bin_in = 10'd333;
    sb.push_back(model(333));
    wait_done("cont1", c1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("cont2", c2);
    check("period_1", 32'(c1 - c0), 32'd11);
    check("period_2", 32'(c2 - c1), 32'd11);
    repeat (3) @(negedge clk);

    // start mid-busy is ignored
    d0 = done_cnt;
    sb.push_back(model(123));
    bin_in = 10'd123;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 begin
      bin_in = 10'd456;
      start  = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("midbusy", c0);
    repeat (20) @(negedge clk);
    check("midbusy_one_done", 32'(done_cnt - d0), 32'd1);

    // Wide instance: overflow saturation and recovery
    run(1'b1, 10000, '{16'h9999, 1'b1, 4'b1111}, "w10000");
    run(1'b1, 42,    '{16'h0042, 1'b0, 4'b0011}, "w42");
    run(1'b1, 9999,  '{16'h9999, 1'b0, 4'b1111}, "w9999");
    run(1'b1, 16383, '{16'h9999, 1'b1, 4'b1111}, "w16383");
    run(1'b1, 0,     '{16'h0000, 1'b0, 4'b0001}, "w0");

    // Random values against the decimal model
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 1023));
      run(1'b0, v, model(v), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      v = int'($urandom_range(0, 16383));
      run(1'b1, v, model(v), $sformatf("wrnd%0d", i));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("sb_w_drained", 32'(sb_w.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
